// File: rtl/decode_pkg.sv
// Shared definitions for the RISC-V decode stage: opcodes, control-field
// encodings and the decoded control bundle carried down the pipeline.
package decode_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00, WB_PC4 = 2'b01, WB_ALU = 2'b10, WB_MEM = 2'b11
    } rf_wr_sel_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000, BR_EQ  = 3'b010, BR_NE   = 3'b011, BR_LT = 3'b100,
        BR_GE   = 3'b101, BR_LTU = 3'b110, BR_GEU  = 3'b111
    } br_type_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SUB = 4'b1000, ALU_SLL = 4'b0001, ALU_SRL = 4'b0101,
        ALU_SRA  = 4'b1101, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011, ALU_XOR = 4'b0100,
        ALU_OR   = 4'b0110, ALU_AND = 4'b0111, ALU_LUI = 4'b1110
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        DM_RD_NONE = 3'b000, DM_LB = 3'b001, DM_LBU = 3'b010, DM_LH  = 3'b011,
        DM_LHU     = 3'b100, DM_LW = 3'b101, DM_LD  = 3'b110, DM_LWU = 3'b111
    } dm_rd_ctrl_e;

    typedef enum logic [2:0] {
        DM_WR_NONE = 3'b000, DM_SB = 3'b001, DM_SH = 3'b010, DM_SW = 3'b011, DM_SD = 3'b100
    } dm_wr_ctrl_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rf_wr_en;
        rf_wr_sel_e  rf_wr_sel;
        logic        do_jump;
        logic        is_branch;
        br_type_e    br_type;
        logic        alu_a_sel;
        logic        alu_b_sel;
        alu_ctrl_e   alu_ctrl;
        logic        alu_word;
        dm_rd_ctrl_e dm_rd_ctrl;
        dm_wr_ctrl_e dm_wr_ctrl;
        logic        rs1_used;
        logic        rs2_used;
        logic        illegal;
        logic        syscall;
        logic        debug;
    } ctrl_bundle_t;

    // alt selects sub/sra; callers only raise it where that variant exists
    function automatic alu_ctrl_e alu_op(input logic alt, input logic [2:0] funct3);
        case (funct3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I/RV64I decoder: instruction word -> control bundle
// plus sign-extended immediate. Illegal encodings yield an all-zero bundle.
module decode_logic
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    output ctrl_bundle_t    ctrl,
    output logic [XLEN-1:0] imm
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0]         opcode_s;
    logic [2:0]         funct3_s;
    logic [6:0]         funct7_s;
    logic signed [11:0] imm_i12_s;
    logic signed [11:0] imm_s12_s;
    logic signed [12:0] imm_b13_s;
    logic signed [31:0] imm_u32_s;
    logic signed [20:0] imm_j21_s;
    logic               shamt_ok_s;
    logic               op_f7_ok_s;
    logic               shift_f7_ok_s;
    ctrl_bundle_t       dec_s;
    logic [XLEN-1:0]    imm_s;
    logic               bad_s;

    assign opcode_s  = inst[6:0];
    assign funct3_s  = inst[14:12];
    assign funct7_s  = inst[31:25];
    assign imm_i12_s = inst[31:20];
    assign imm_s12_s = {inst[31:25], inst[11:7]};
    assign imm_b13_s = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u32_s = {inst[31:12], 12'b0};
    assign imm_j21_s = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // shamt[5] only exists on RV64; funct7 alt bit only for sub/sra
    assign shamt_ok_s    = IS_RV64 || (inst[25] == 1'b0);
    assign op_f7_ok_s    = (funct7_s == 7'b0000000) ||
                           ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
    assign shift_f7_ok_s = (inst[31:26] == 6'b000000) ||
                           ((inst[31:26] == 6'b010000) && (funct3_s == 3'b101));

    // Main decode table; field values before the legality override
    always_comb begin
        dec_s = '0;
        imm_s = '0;
        bad_s = 1'b0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: begin
                dec_s.rd        = inst[11:7];
                dec_s.rf_wr_en  = 1'b1;
                dec_s.rf_wr_sel = WB_ALU;
                dec_s.alu_b_sel = 1'b1;
                dec_s.alu_ctrl  = (opcode_s == OPC_LUI) ? ALU_LUI : ALU_ADD;
                imm_s           = XLEN'(imm_u32_s);
            end
            OPC_JAL: begin
                dec_s.rd        = inst[11:7];
                dec_s.rf_wr_en  = 1'b1;
                dec_s.rf_wr_sel = WB_PC4;
                dec_s.do_jump   = 1'b1;
                dec_s.alu_b_sel = 1'b1;
                imm_s           = XLEN'(imm_j21_s);
            end
            OPC_JALR: begin
                dec_s.rd        = inst[11:7];
                dec_s.rs1       = inst[19:15];
                dec_s.rs1_used  = 1'b1;
                dec_s.rf_wr_en  = 1'b1;
                dec_s.rf_wr_sel = WB_PC4;
                dec_s.do_jump   = 1'b1;
                dec_s.alu_a_sel = 1'b1;
                dec_s.alu_b_sel = 1'b1;
                imm_s           = XLEN'(imm_i12_s);
                bad_s           = (funct3_s != 3'b000);
            end
            OPC_BRANCH: begin
                dec_s.rs1       = inst[19:15];
                dec_s.rs2       = inst[24:20];
                dec_s.rs1_used  = 1'b1;
                dec_s.rs2_used  = 1'b1;
                dec_s.is_branch = 1'b1;
                dec_s.alu_b_sel = 1'b1;
                imm_s           = XLEN'(imm_b13_s);
                case (funct3_s)
                    3'b000:  dec_s.br_type = BR_EQ;
                    3'b001:  dec_s.br_type = BR_NE;
                    3'b100:  dec_s.br_type = BR_LT;
                    3'b101:  dec_s.br_type = BR_GE;
                    3'b110:  dec_s.br_type = BR_LTU;
                    3'b111:  dec_s.br_type = BR_GEU;
                    default: bad_s = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_s.rd        = inst[11:7];
                dec_s.rs1       = inst[19:15];
                dec_s.rs1_used  = 1'b1;
                dec_s.rf_wr_en  = 1'b1;
                dec_s.rf_wr_sel = WB_MEM;
                dec_s.alu_a_sel = 1'b1;
                dec_s.alu_b_sel = 1'b1;
                imm_s           = XLEN'(imm_i12_s);
                case (funct3_s)
                    3'b000:  dec_s.dm_rd_ctrl = DM_LB;
                    3'b001:  dec_s.dm_rd_ctrl = DM_LH;
                    3'b010:  dec_s.dm_rd_ctrl = DM_LW;
                    3'b100:  dec_s.dm_rd_ctrl = DM_LBU;
                    3'b101:  dec_s.dm_rd_ctrl = DM_LHU;
                    3'b011:  begin dec_s.dm_rd_ctrl = DM_LD;  bad_s = !IS_RV64; end
                    3'b110:  begin dec_s.dm_rd_ctrl = DM_LWU; bad_s = !IS_RV64; end
                    default: bad_s = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_s.rs1       = inst[19:15];
                dec_s.rs2       = inst[24:20];
                dec_s.rs1_used  = 1'b1;
                dec_s.rs2_used  = 1'b1;
                dec_s.alu_a_sel = 1'b1;
                dec_s.alu_b_sel = 1'b1;
                imm_s           = XLEN'(imm_s12_s);
                case (funct3_s)
                    3'b000:  dec_s.dm_wr_ctrl = DM_SB;
                    3'b001:  dec_s.dm_wr_ctrl = DM_SH;
                    3'b010:  dec_s.dm_wr_ctrl = DM_SW;
                    3'b011:  begin dec_s.dm_wr_ctrl = DM_SD; bad_s = !IS_RV64; end
                    default: bad_s = 1'b1;
                endcase
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                dec_s.rd        = inst[11:7];
                dec_s.rs1       = inst[19:15];
                dec_s.rs1_used  = 1'b1;
                dec_s.rf_wr_en  = 1'b1;
                dec_s.rf_wr_sel = WB_ALU;
                dec_s.alu_a_sel = 1'b1;
                dec_s.alu_b_sel = 1'b1;
                dec_s.alu_ctrl  = alu_op(inst[30] && (funct3_s == 3'b101), funct3_s);
                imm_s           = XLEN'(imm_i12_s);
                if (opcode_s == OPC_OP_IMM) begin
                    if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                        bad_s = !(shift_f7_ok_s && shamt_ok_s);
                    end else begin
                        bad_s = 1'b0;
                    end
                end else begin
                    dec_s.alu_word = 1'b1;
                    case (funct3_s)
                        3'b000:         bad_s = !IS_RV64;
                        3'b001, 3'b101: bad_s = !(IS_RV64 && op_f7_ok_s);
                        default:        bad_s = 1'b1;
                    endcase
                end
            end
            OPC_OP, OPC_OP_32: begin
                dec_s.rd        = inst[11:7];
                dec_s.rs1       = inst[19:15];
                dec_s.rs2       = inst[24:20];
                dec_s.rs1_used  = 1'b1;
                dec_s.rs2_used  = 1'b1;
                dec_s.rf_wr_en  = 1'b1;
                dec_s.rf_wr_sel = WB_ALU;
                dec_s.alu_a_sel = 1'b1;
                dec_s.alu_ctrl  = alu_op(inst[30], funct3_s);
                if (opcode_s == OPC_OP) begin
                    bad_s = !op_f7_ok_s;
                end else begin
                    dec_s.alu_word = 1'b1;
                    bad_s = !(IS_RV64 && op_f7_ok_s &&
                              ((funct3_s == 3'b000) || (funct3_s == 3'b001) || (funct3_s == 3'b101)));
                end
            end
            OPC_MISC_MEM: begin
                bad_s = 1'b0;
            end
            OPC_SYSTEM: begin
                if (inst == 32'h0000_0073) begin
                    dec_s.syscall = 1'b1;
                end else if (inst == 32'h0010_0073) begin
                    dec_s.debug = 1'b1;
                end else begin
                    bad_s = 1'b1;
                end
            end
            default: bad_s = 1'b1;
        endcase
    end

    // Illegal encodings flow downstream with every control field cleared
    always_comb begin
        if (bad_s) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            imm          = '0;
        end else begin
            ctrl = dec_s;
            imm  = imm_s;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder at the input, then a two-entry output/skid
// buffer so that in_ready is driven straight from a flop.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rf_wr_en,
    output logic [1:0]      out_rf_wr_sel,
    output logic            out_do_jump,
    output logic            out_is_branch,
    output logic [2:0]      out_br_type,
    output logic            out_alu_a_sel,
    output logic            out_alu_b_sel,
    output logic [3:0]      out_alu_ctrl,
    output logic            out_alu_word,
    output logic [2:0]      out_dm_rd_ctrl,
    output logic [2:0]      out_dm_wr_ctrl,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_illegal,
    output logic            out_syscall,
    output logic            out_debug
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        ctrl_bundle_t    ctrl;
    } entry_t;

    ctrl_bundle_t    dec_ctrl_s;
    logic [XLEN-1:0] dec_imm_s;
    entry_t          dec_s;
    entry_t          r0_r, r1_r, r0_nxt_s, r1_nxt_s;
    logic            r0_valid_r, r1_valid_r, r0_valid_nxt_s, r1_valid_nxt_s;
    logic            in_ready_r;
    logic            in_fire_s, out_fire_s;

    decode_logic #(.XLEN(XLEN)) u_decode_logic (
        .inst (in_inst),
        .ctrl (dec_ctrl_s),
        .imm  (dec_imm_s)
    );

    assign dec_s      = '{pc: in_pc, imm: dec_imm_s, ctrl: dec_ctrl_s};
    assign in_fire_s  = in_valid && in_ready_r;
    assign out_fire_s = r0_valid_r && out_ready;

    // Buffer next-state: skid entry drains first so order is preserved
    always_comb begin
        r0_nxt_s       = r0_r;
        r1_nxt_s       = r1_r;
        r0_valid_nxt_s = r0_valid_r;
        r1_valid_nxt_s = r1_valid_r;
        if (flush) begin
            r0_valid_nxt_s = 1'b0;
            r1_valid_nxt_s = 1'b0;
        end else if (r1_valid_r && (!r0_valid_r || out_fire_s)) begin
            r0_nxt_s       = r1_r;
            r0_valid_nxt_s = 1'b1;
            r1_valid_nxt_s = 1'b0;
        end else if (in_fire_s && (!r0_valid_r || out_fire_s)) begin
            r0_nxt_s       = dec_s;
            r0_valid_nxt_s = 1'b1;
        end else if (in_fire_s) begin
            r1_nxt_s       = dec_s;
            r1_valid_nxt_s = 1'b1;
        end else if (out_fire_s) begin
            r0_valid_nxt_s = 1'b0;
        end else begin
            r0_valid_nxt_s = r0_valid_r;
        end
    end

    // Buffer registers; in_ready mirrors the skid entry being free
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_r       <= '0;
            r1_r       <= '0;
            r0_valid_r <= 1'b0;
            r1_valid_r <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            r0_r       <= r0_nxt_s;
            r1_r       <= r1_nxt_s;
            r0_valid_r <= r0_valid_nxt_s;
            r1_valid_r <= r1_valid_nxt_s;
            in_ready_r <= !r1_valid_nxt_s;
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = r0_valid_r;
    assign out_pc         = r0_r.pc;
    assign out_imm        = r0_r.imm;
    assign out_rd         = r0_r.ctrl.rd;
    assign out_rs1        = r0_r.ctrl.rs1;
    assign out_rs2        = r0_r.ctrl.rs2;
    assign out_rf_wr_en   = r0_r.ctrl.rf_wr_en;
    assign out_rf_wr_sel  = r0_r.ctrl.rf_wr_sel;
    assign out_do_jump    = r0_r.ctrl.do_jump;
    assign out_is_branch  = r0_r.ctrl.is_branch;
    assign out_br_type    = r0_r.ctrl.br_type;
    assign out_alu_a_sel  = r0_r.ctrl.alu_a_sel;
    assign out_alu_b_sel  = r0_r.ctrl.alu_b_sel;
    assign out_alu_ctrl   = r0_r.ctrl.alu_ctrl;
    assign out_alu_word   = r0_r.ctrl.alu_word;
    assign out_dm_rd_ctrl = r0_r.ctrl.dm_rd_ctrl;
    assign out_dm_wr_ctrl = r0_r.ctrl.dm_wr_ctrl;
    assign out_rs1_used   = r0_r.ctrl.rs1_used;
    assign out_rs2_used   = r0_r.ctrl.rs2_used;
    assign out_illegal    = r0_r.ctrl.illegal;
    assign out_syscall    = r0_r.ctrl.syscall;
    assign out_debug      = r0_r.ctrl.debug;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV64 and an RV32 instance share stimulus;
// expected values are hand-computed from the instruction encodings.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_rf_wr_en, a_do_jump, a_is_branch, a_alu_a_sel, a_alu_b_sel;
    logic        a_alu_word, a_rs1_used, a_rs2_used, a_illegal, a_syscall, a_debug;
    logic [63:0] a_out_pc, a_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [1:0]  a_rf_wr_sel;
    logic [2:0]  a_br_type, a_dm_rd, a_dm_wr;
    logic [3:0]  a_alu_ctrl;

    logic        b_in_ready, b_out_valid, b_rf_wr_en, b_do_jump, b_is_branch, b_alu_a_sel, b_alu_b_sel;
    logic        b_alu_word, b_rs1_used, b_rs2_used, b_illegal, b_syscall, b_debug;
    logic [31:0] b_out_pc, b_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [1:0]  b_rf_wr_sel;
    logic [2:0]  b_br_type, b_dm_rd, b_dm_wr;
    logic [3:0]  b_alu_ctrl;

    int errors_cnt = 0;
    int checks_cnt = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_imm),
        .out_rf_wr_en(a_rf_wr_en), .out_rf_wr_sel(a_rf_wr_sel), .out_do_jump(a_do_jump),
        .out_is_branch(a_is_branch), .out_br_type(a_br_type), .out_alu_a_sel(a_alu_a_sel),
        .out_alu_b_sel(a_alu_b_sel), .out_alu_ctrl(a_alu_ctrl), .out_alu_word(a_alu_word),
        .out_dm_rd_ctrl(a_dm_rd), .out_dm_wr_ctrl(a_dm_wr), .out_rs1_used(a_rs1_used),
        .out_rs2_used(a_rs2_used), .out_illegal(a_illegal), .out_syscall(a_syscall),
        .out_debug(a_debug)
    );

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_imm),
        .out_rf_wr_en(b_rf_wr_en), .out_rf_wr_sel(b_rf_wr_sel), .out_do_jump(b_do_jump),
        .out_is_branch(b_is_branch), .out_br_type(b_br_type), .out_alu_a_sel(b_alu_a_sel),
        .out_alu_b_sel(b_alu_b_sel), .out_alu_ctrl(b_alu_ctrl), .out_alu_word(b_alu_word),
        .out_dm_rd_ctrl(b_dm_rd), .out_dm_wr_ctrl(b_dm_wr), .out_rs1_used(b_rs1_used),
        .out_rs2_used(b_rs2_used), .out_illegal(b_illegal), .out_syscall(b_syscall),
        .out_debug(b_debug)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 64'h0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_out_valid", {63'h0, a_out_valid}, 64'h0);
        check_eq("rst_in_ready", {63'h0, a_in_ready}, 64'h1);
        check_eq("rst_pc", a_out_pc, 64'h0);
        check_eq("rst_imm", a_imm, 64'h0);
        check_eq("rst_wr_sel", {62'h0, a_rf_wr_sel}, 64'h0);
        check_eq("rst32_out_valid", {63'h0, b_out_valid}, 64'h0);

        // out_ready high while empty: no effect
        out_ready = 1'b1;
        tick();
        check_eq("idle_out_valid", {63'h0, a_out_valid}, 64'h0);

        // addi x1,x0,5
        offer(32'h0050_0093, 64'h100);
        tick();
        check_eq("addi_valid", {63'h0, a_out_valid}, 64'h1);
        check_eq("addi_pc", a_out_pc, 64'h100);
        check_eq("addi_rd", {59'h0, a_rd}, 64'd1);
        check_eq("addi_imm", a_imm, 64'd5);
        check_eq("addi_alu", {60'h0, a_alu_ctrl}, 64'h0);
        check_eq("addi_wr_sel", {62'h0, a_rf_wr_sel}, 64'h2);
        check_eq("addi_b_sel", {63'h0, a_alu_b_sel}, 64'h1);
        check_eq("addi_rs2_used", {63'h0, a_rs2_used}, 64'h0);
        check_eq("addi32_imm", {32'h0, b_imm}, 64'd5);

        // ld x2,8(x1)
        offer(32'h0080_B103, 64'h104);
        tick();
        check_eq("ld_dm_rd", {61'h0, a_dm_rd}, 64'h6);
        check_eq("ld_wr_sel", {62'h0, a_rf_wr_sel}, 64'h3);
        check_eq("ld_imm", a_imm, 64'd8);
        check_eq("ld_rs1", {59'h0, a_rs1}, 64'd1);
        check_eq("ld_illegal", {63'h0, a_illegal}, 64'h0);
        check_eq("ld32_valid", {63'h0, b_out_valid}, 64'h1);
        check_eq("ld32_illegal", {63'h0, b_illegal}, 64'h1);
        check_eq("ld32_wr_en", {63'h0, b_rf_wr_en}, 64'h0);
        check_eq("ld32_dm_rd", {61'h0, b_dm_rd}, 64'h0);

        // beq x0,x0,-4
        offer(32'hFE00_0EE3, 64'h108);
        tick();
        check_eq("beq_br_type", {61'h0, a_br_type}, 64'h2);
        check_eq("beq_is_branch", {63'h0, a_is_branch}, 64'h1);
        check_eq("beq_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("beq_rs2_used", {63'h0, a_rs2_used}, 64'h1);
        check_eq("beq_a_sel", {63'h0, a_alu_a_sel}, 64'h0);
        check_eq("beq_wr_en", {63'h0, a_rf_wr_en}, 64'h0);
        check_eq("beq32_imm", {32'h0, b_imm}, 64'h0000_0000_FFFF_FFFC);

        // addw x3,x1,x2
        offer(32'h0020_81BB, 64'h10C);
        tick();
        check_eq("addw_word", {63'h0, a_alu_word}, 64'h1);
        check_eq("addw_alu", {60'h0, a_alu_ctrl}, 64'h0);
        check_eq("addw_wr_sel", {62'h0, a_rf_wr_sel}, 64'h2);
        check_eq("addw_b_sel", {63'h0, a_alu_b_sel}, 64'h0);
        check_eq("addw_rs2", {59'h0, a_rs2}, 64'd2);
        check_eq("addw32_illegal", {63'h0, b_illegal}, 64'h1);

        // srai x5,x6,33: 6-bit shamt legal only on RV64
        offer(32'h4213_5293, 64'h110);
        tick();
        check_eq("srai_alu", {60'h0, a_alu_ctrl}, 64'hD);
        check_eq("srai_illegal", {63'h0, a_illegal}, 64'h0);
        check_eq("srai32_illegal", {63'h0, b_illegal}, 64'h1);

        // ecall
        offer(32'h0000_0073, 64'h114);
        tick();
        check_eq("ecall_syscall", {63'h0, a_syscall}, 64'h1);
        check_eq("ecall_wr_en", {63'h0, a_rf_wr_en}, 64'h0);
        check_eq("ecall_illegal", {63'h0, a_illegal}, 64'h0);

        in_valid = 1'b0;
        tick();
        check_eq("drain_valid", {63'h0, a_out_valid}, 64'h0);

        // Backpressure: three back-to-back offers with out_ready low
        out_ready = 1'b0;
        offer(32'h0010_0093, 64'h200);
        tick();
        check_eq("bp_a_pc", a_out_pc, 64'h200);
        check_eq("bp_a_in_ready", {63'h0, a_in_ready}, 64'h1);
        offer(32'h0020_0113, 64'h204);
        tick();
        check_eq("bp_b_in_ready", {63'h0, a_in_ready}, 64'h0);
        check_eq("bp_hold_pc", a_out_pc, 64'h200);
        offer(32'h0030_0193, 64'h208);
        tick(); tick();
        check_eq("bp_stall_pc", a_out_pc, 64'h200);
        check_eq("bp_stall_rd", {59'h0, a_rd}, 64'd1);
        check_eq("bp_stall_valid", {63'h0, a_out_valid}, 64'h1);
        out_ready = 1'b1;
        tick();
        check_eq("rel_b_pc", a_out_pc, 64'h204);
        check_eq("rel_b_rd", {59'h0, a_rd}, 64'd2);
        check_eq("rel_in_ready", {63'h0, a_in_ready}, 64'h1);
        tick();
        in_valid = 1'b0;
        check_eq("rel_c_pc", a_out_pc, 64'h208);
        check_eq("rel_c_rd", {59'h0, a_rd}, 64'd3);
        tick();
        check_eq("rel_empty", {63'h0, a_out_valid}, 64'h0);

        // Flush with both entries full and an offer pending
        out_ready = 1'b0;
        offer(32'h0040_0213, 64'h300);
        tick();
        offer(32'h0050_0293, 64'h304);
        tick();
        check_eq("fl_full_in_ready", {63'h0, a_in_ready}, 64'h0);
        offer(32'h0060_0313, 64'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check_eq("fl_out_valid", {63'h0, a_out_valid}, 64'h0);
        check_eq("fl_in_ready", {63'h0, a_in_ready}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("fl_never", {63'h0, a_out_valid}, 64'h0);
        end

        // Mid-stream reset, same outcome
        out_ready = 1'b0;
        offer(32'h0070_0393, 64'h400);
        tick();
        offer(32'h0080_0413, 64'h404);
        tick();
        offer(32'h0090_0493, 64'h408);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check_eq("mrst_out_valid", {63'h0, a_out_valid}, 64'h0);
        check_eq("mrst_in_ready", {63'h0, a_in_ready}, 64'h1);
        check_eq("mrst_pc", a_out_pc, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mrst_never", {63'h0, a_out_valid}, 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

- Registered, parametrised RISC-V instruction decode stage with a valid/ready handshake on both sides.
- Decodes RV32I, or RV64I when XLEN=64 (ld/sd/lwu and the W-ops), generates the sign-extended immediate and flags illegal encodings.
- Sits between fetch and execute.
- Holds up to two decoded instructions in a skid buffer so that in_ready is a registered signal; supports pipeline flush.

## Interface

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- flush  input  1  drop every held and incoming instruction.
- in_valid  input  1  fetch offers an instruction.
- in_ready  output  1  stage can accept; equals !skid_full.
- in_inst  input  32  instruction word.
- in_pc  input  XLEN  instruction PC.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts the bundle.
- out_pc  output  XLEN  PC of the bundle.
- out_rd, out_rs1, out_rs2  output  5 each  register indices.
- out_imm  output  XLEN  sign-extended immediate (I/S/B/U/J formats).
- out_rf_wr_en  output  1  writes rd.
- out_rf_wr_sel  output  2  rd source: 00 none, 01 pc+4, 10 ALU, 11 memory.
- out_do_jump, out_is_branch  output  1 each  jal/jalr; conditional branch.
- out_br_type  output  3  000 none, 010 beq, 011 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
- out_alu_a_sel, out_alu_b_sel  output  1 each  A operand is rs1; B operand is the immediate.
- out_alu_ctrl  output  4  0000 add, 1000 sub, 0001 sll, 0101 srl, 1101 sra, 0010 slt, 0011 sltu, 0100 xor, 0110 or, 0111 and, 1110 lui.
- out_alu_word  output  1  32-bit W-op; result is sign-extended.
- out_dm_rd_ctrl  output  3  001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 110 ld, 111 lwu, 000 none.
- out_dm_wr_ctrl  output  3  001 sb, 010 sh, 011 sw, 100 sd, 000 none.
- out_rs1_used, out_rs2_used  output  1 each  operand read flags, for hazard detection.
- out_illegal, out_syscall, out_debug  output  1 each  illegal encoding; ecall; ebreak.

## Operation

Decode:
- Decoding is combinational on in_inst; the result is captured as a bundle on acceptance.
- Every field defaults to 0, including alu_ctrl; no latches.
- Loads, stores, branches, jal, jalr, auipc and add/addi use alu_ctrl=0000.
- rs1_used is set for R, I (including loads and jalr), S and B formats.
- rs2_used is set for R, S and B formats.
- alu_a_sel is 0 for auipc, jal and branches (A operand is the PC).

XLEN-dependent rules:
- XLEN=64: shift immediates use a 6-bit shamt, and funct7[6:1] is checked.
- XLEN=64 adds: opcode 0x1B (addiw, slliw, srliw, sraiw) and opcode 0x3B (addw, subw, sllw, srlw, sraw), all with alu_word=1; plus ld, sd and lwu.
- XLEN=32: those encodings, and any shamt[5]=1, are illegal.

Other encodings:
- fence (0x0F) is legal and has no effect: all control fields 0.
- ecall/ebreak are legal; they set syscall/debug and rf_wr_en=0.
- Any unlisted encoding sets illegal=1 and zeroes every control field; the bundle still flows downstream.

Buffer (R0 = output register, R1 = skid register):
- A transfer happens when valid&ready on the respective side (in_fire, out_fire).
- If R1 is full and (R0 is empty or out_fire): R0<=R1, and R1 becomes empty.
- Else if in_fire and (R0 is empty or out_fire): R0<=input.
- Else if in_fire and R0 is full and !out_fire: R1<=input.
- Order is preserved.
- out_valid and all out_* fields hold stable while out_valid & !out_ready.

Priority:
- rst > flush > normal operation.
- flush empties R0 and R1, and discards any in_fire in the same cycle.

## Timing

- Latency is 1 cycle from in_fire to out_valid when R0 is empty.
- Sustained throughput is 1 instruction/cycle while out_ready=1.
- in_ready comes directly from a flop.
- It falls the cycle after R1 fills and rises the cycle after R1 drains.
- After reset: out_valid=0, all out_* fields 0, in_ready=1.
- After flush: out_valid=0 and in_ready=1 on the next cycle.
- out_ready may be asserted while out_valid=0; this has no effect.

## Structure

- Package decode_pkg holds:
  - opcode constants;
  - the rf_wr_sel, br_type, alu_ctrl, dm_rd_ctrl and dm_wr_ctrl encodings;
  - the packed struct ctrl_bundle_t, parametrised via XLEN-wide fields in the module.
- Sub-module decode_logic (purely combinational: inst -> ctrl_bundle_t, XLEN parameter) is instantiated once at the input.
- decode_stage itself is the two-entry buffer and its handshake.

## Test plan

- addi x1,x0,5 (0x00500093) → one cycle later out_valid=1, rd=1, imm=5, alu_ctrl=0000, rf_wr_sel=10, alu_b_sel=1.
- ld x2,8(x1) (0x0080B103):
  - XLEN=64 → dm_rd_ctrl=110, rf_wr_sel=11, imm=8;
  - XLEN=32 → illegal=1, rf_wr_en=0.
- beq x0,x0,-4 (0xFE000EE3) → br_type=010, is_branch=1, imm=all-ones minus 3 (-4), rs2_used=1.
- addw x3,x1,x2 (0x002081BB), XLEN=64 → alu_word=1, alu_ctrl=0000, rf_wr_sel=10, alu_b_sel=0.
- Backpressure: out_ready=0 while 3 back-to-back instructions are offered → the first two are accepted, in_ready=0 the cycle after the second, and the third waits. Raising out_ready then releases them in order at 1/cycle.
- flush with R0 and R1 full and in_valid=1 → next cycle out_valid=0 and in_ready=1, and none of the three instructions ever appears. A mid-stream rst gives the same outcome.
